debugger_uart_tx_arbiter: RTL

- Multi-channel UART transmit front-end for the debugger. It accepts word-write requests from NUM_CHANNELS producers, such as the control unit, register printer and memory printer.
- Each request is buffered per channel. One channel is granted at a time, by fixed priority or round robin.
- The granted word is serialised into UART_BUS_SIZE bytes toward the UART TX FIFO, with back-pressure from i_uart_full.
- It replaces the hard-wired OR of start strobes plus priority data register, and the single-channel writer, in the debugger top.

---
 rtl/debugger_uart_tx_arbiter_pkg.sv | 16 +
 rtl/debugger_channel_arbiter.sv | 32 +++
 rtl/debugger_uart_tx_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/debugger_uart_tx_arbiter_pkg.sv
// Shared encodings for the debugger UART transmit arbiter: FSM states, arbitration modes and byte order.
// Pure declarations; no logic and no latency.
package debugger_uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        DEBUGGER_TXARB_IDLE = 2'd0,
        DEBUGGER_TXARB_SEND = 2'd1,
        DEBUGGER_TXARB_DONE = 2'd2
    } txarb_state_t;

    localparam int ARB_FIXED            = 0;
    localparam int ARB_ROUND_ROBIN      = 1;
    localparam int BYTE_ORDER_MSB_FIRST = 0;
    localparam int BYTE_ORDER_LSB_FIRST = 1;

endpackage

// File: rtl/debugger_channel_arbiter.sv
// Combinational one-hot channel picker: lowest pending index, or first pending index after pointer.
// Zero latency; no backpressure, the caller decides when to act on the winner.
module debugger_channel_arbiter #(
    parameter int NUM_CHANNELS = 3,
    parameter int PTR_W        = 2
) (
    input  logic [NUM_CHANNELS-1:0] pending,
    input  logic [PTR_W-1:0]        pointer,
    input  logic                    mode,
    output logic [NUM_CHANNELS-1:0] winner,
    output logic                    any_pending
);

    assign any_pending = |pending;

    // Search order starts just after the pointer in round robin, at index 0 otherwise.
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= NUM_CHANNELS; off++) begin
            idx = mode ? (int'(pointer) + off) % NUM_CHANNELS : off - 1;
            if (!found && pending[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/debugger_uart_tx_arbiter.sv
// Buffers one word per producer, grants one channel at a time and serialises its word into UART bytes.
// First byte two cycles after the strobe; i_uart_full stalls the byte stream without losing or repeating a byte.
module debugger_uart_tx_arbiter
    import debugger_uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_CHANNELS      = 3,
    parameter int UART_BUS_SIZE     = 8,
    parameter int DATA_OUT_BUS_SIZE = 32,
    parameter int ARBITRATION_MODE  = 0,
    parameter int BYTE_ORDER        = 0
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic [NUM_CHANNELS-1:0]                   i_start_wr,
    input  logic [NUM_CHANNELS*DATA_OUT_BUS_SIZE-1:0] i_wr_data,
    input  logic                                      i_uart_full,
    output logic                                      o_uart_wr,
    output logic [UART_BUS_SIZE-1:0]                  o_uart_data_wr,
    output logic [NUM_CHANNELS-1:0]                   o_wr_end,
    output logic [NUM_CHANNELS-1:0]                   o_grant,
    output logic                                      o_busy,
    output logic [NUM_CHANNELS-1:0]                   o_overflow
);

    localparam int   BYTES     = DATA_OUT_BUS_SIZE / UART_BUS_SIZE;
    localparam int   CNT_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int   PTR_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic RR_MODE   = (ARBITRATION_MODE != ARB_FIXED);
    localparam logic LSB_FIRST = (BYTE_ORDER == BYTE_ORDER_LSB_FIRST);

    txarb_state_t state_q, state_d;

    logic [DATA_OUT_BUS_SIZE-1:0] buf_q [NUM_CHANNELS];
    logic [DATA_OUT_BUS_SIZE-1:0] shift_q, shift_next;
    logic [NUM_CHANNELS-1:0]      pending_q, pending_kept, capture, overflow_set;
    logic [NUM_CHANNELS-1:0]      grant_q, overflow_q, win_onehot;
    logic [CNT_W-1:0]             cnt_q;
    logic [PTR_W-1:0]             ptr_q, owner_q, win_idx;
    logic [UART_BUS_SIZE-1:0]     cur_byte;
    logic                         any_pending, select, write, last_byte;

    debugger_channel_arbiter #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .PTR_W        (PTR_W)
    ) u_arb (
        .pending     (pending_q),
        .pointer     (ptr_q),
        .mode        (RR_MODE),
        .winner      (win_onehot),
        .any_pending (any_pending)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (win_onehot[i]) win_idx = PTR_W'(i);
        end
    end

    assign last_byte = (cnt_q == CNT_W'(BYTES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= DEBUGGER_TXARB_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        select  = 1'b0;
        write   = 1'b0;
        case (state_q)
            DEBUGGER_TXARB_IDLE: begin
                if (any_pending) begin
                    select  = 1'b1;
                    state_d = DEBUGGER_TXARB_SEND;
                end
            end
            DEBUGGER_TXARB_SEND: begin
                if (!i_uart_full) begin
                    write = 1'b1;
                    if (last_byte) state_d = DEBUGGER_TXARB_DONE;
                end
            end
            DEBUGGER_TXARB_DONE: state_d = DEBUGGER_TXARB_IDLE;
            default:             state_d = DEBUGGER_TXARB_IDLE;
        endcase
    end

    // The winner's flag is cleared before new strobes are looked at, so a same-cycle strobe re-arms it.
    always_comb begin
        pending_kept = select ? (pending_q & ~win_onehot) : pending_q;
        capture      = i_start_wr & ~pending_kept;
        overflow_set = i_start_wr & pending_kept;
    end

    always_comb begin
        if (LSB_FIRST) begin
            cur_byte   = shift_q[UART_BUS_SIZE-1:0];
            shift_next = shift_q >> UART_BUS_SIZE;
        end else begin
            cur_byte   = shift_q[DATA_OUT_BUS_SIZE-1 -: UART_BUS_SIZE];
            shift_next = shift_q << UART_BUS_SIZE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pending_q  <= '0;
            overflow_q <= '0;
            grant_q    <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= PTR_W'(NUM_CHANNELS - 1);
            for (int k = 0; k < NUM_CHANNELS; k++) buf_q[k] <= '0;
        end else begin
            pending_q  <= pending_kept | capture;
            overflow_q <= overflow_q | overflow_set;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (capture[k]) buf_q[k] <= i_wr_data[k*DATA_OUT_BUS_SIZE +: DATA_OUT_BUS_SIZE];
            end
            if (select) begin
                shift_q <= buf_q[win_idx];
                cnt_q   <= '0;
                grant_q <= win_onehot;
                owner_q <= win_idx;
            end else if (write) begin
                shift_q <= shift_next;
                cnt_q   <= cnt_q + 1'b1;
            end
            if (state_q == DEBUGGER_TXARB_DONE) begin
                grant_q <= '0;
                ptr_q   <= owner_q;
            end
        end
    end

    assign o_uart_wr      = write;
    assign o_uart_data_wr = (state_q == DEBUGGER_TXARB_SEND) ? cur_byte : '0;
    assign o_wr_end       = (state_q == DEBUGGER_TXARB_DONE) ? grant_q : '0;
    assign o_grant        = grant_q;
    assign o_busy         = (state_q != DEBUGGER_TXARB_IDLE);
    assign o_overflow     = overflow_q;

endmodule
